cordic_vec_iter: RTL
====================

CORDIC_VEC_ITER -- requirements
Module: cordic_vec_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: bit width of all data ports.
REQ-002 SHALL have parameter ITER, default 20: number of micro-rotation iterations.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port x  input  WIDTH: signed Cartesian X coordinate, Q4.20 format.
REQ-006 SHALL have port y  input  WIDTH: signed Cartesian Y coordinate, Q4.20 format.
REQ-007 SHALL have port data_loaded  input  1: start strobe that captures x/y.
REQ-008 SHALL have port angle  output  WIDTH: atan2(y,x) in radians, signed Q4.20.
REQ-009 SHALL have port magnitude  output  WIDTH: vector length, unsigned value in a signed Q4.20 field.
REQ-010 SHALL have port data_computed  output  1: single-cycle result-valid pulse.

Function
REQ-011 SHALL implement the FSM states IDLE -> PRE -> ROT -> (SCALE) -> DONE -> IDLE.
REQ-012 IDLE SHALL capture x/y on a clock edge where data_loaded=1, then go to PRE.
REQ-013 PRE SHALL perform quadrant pre-rotation, with angle accumulator z as follows: x>=0 -> unchanged, z=0; x<0,y>=0 -> (y,-x), z=+pi/2 (0x1921FB); x<0,y<0 -> (-y,x), z=-pi/2 (0xE6DE05).
REQ-014 ROT SHALL run ITER cycles, one per iteration i=0..ITER-1: d = (y_i<0) ? +1 : -1; x += -d*(y>>>i); y += d*(x>>>i); z -= d*atan(2^-i).
REQ-015 The iteration counter SHALL be ceil(log2(ITER+1)) bits wide and SHALL exit ROT at count ITER-1.
REQ-016 The internal x/y datapath SHALL be WIDTH+2 bits and SHALL use arithmetic shifts; z SHALL be WIDTH bits.
REQ-017 The valid input range SHALL be |x|,|y| <= 2.0; results outside that range are undefined.
REQ-018 DONE SHALL register angle=z and magnitude=x[WIDTH-1:0], assert data_computed for exactly one cycle, then return to IDLE.
REQ-019 Latency from the data_loaded sampling edge to data_computed high SHALL be ITER+2 cycles, or ITER+3 with CORDIC_GAIN_COMP_EN.
REQ-020 data_loaded asserted in any state other than IDLE SHALL be ignored; the result in flight SHALL be unaffected.
REQ-021 data_loaded held high in IDLE SHALL start one computation per IDLE visit.
REQ-022 angle and magnitude SHALL hold their last values until the next DONE.
REQ-023 x=y=0 SHALL yield angle=0 and magnitude=0 (+/-2 LSB).
REQ-024 x<0, y=0 SHALL yield angle=+pi (0x3243F7, +/-2^-16 tolerance), never -pi.

Reset
REQ-025 While rst=1, the block SHALL force state IDLE and angle=0, magnitude=0, data_computed=0, regardless of clk.
REQ-026 Reset asserted mid-computation SHALL discard that computation without producing a data_computed pulse.
REQ-027 The first data_loaded sampled after rst deasserts SHALL be accepted.

Configuration
REQ-028 Macro CORDIC_GAIN_COMP_EN defined: the block SHALL add the SCALE state, multiply x by K=0.607252935 (0x09B74E), round to nearest, and output the true magnitude.
REQ-029 Macro CORDIC_GAIN_COMP_EN undefined: the block SHALL omit SCALE and the multiplier, and magnitude SHALL equal 1.646760258*|v|.

Structure
REQ-030 Package cordic_pkg SHALL hold the FRAC=20 constant, PI (0x3243F7), PI_2 (0x1921FB), K (0x09B74E) and the FSM state enum.
REQ-031 Sub-module cordic_atan_rom SHALL be combinational, take input i, return atan(2^-i) in Q4.20 (entry 0 = 0x0C90FE), and SHALL be shared with cordic_iter.

Verification (pass criterion: top 16 bits match expected)
REQ-032 Bench SHALL apply (x,y)=(1.0,0) -> angle 0x000000; magnitude 0x100000 with the macro, 0x1A5921 without.
REQ-033 Bench SHALL apply (1.0,1.0) -> angle 0x0C90FE; magnitude 0x16A09E with the macro.
REQ-034 Bench SHALL apply (0,-0.5) -> angle 0xE6DE05, and (-1.0,0) -> angle 0x3243F7.
REQ-035 Bench SHALL apply (0,0) -> angle 0, magnitude 0, with data_computed exactly ITER+2 (or ITER+3) cycles after the start.
REQ-036 Bench SHALL pulse data_loaded again 5 cycles into a run -> result matches the first input, and only one data_computed pulse occurs.
REQ-037 Bench SHALL assert rst at ROT iteration 10 -> outputs zero immediately, no data_computed pulse, and the next start completes correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants (Q4.20) and FSM state type for the iterative CORDIC vectoring block.
package cordic_pkg;

  localparam int FRAC = 20;

  localparam logic [23:0] PI   = 24'h3243F7;
  localparam logic [23:0] PI_2 = 24'h1921FB;
  localparam logic [23:0] K    = 24'h09B74E;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ROT,
    SCALE,
    DONE
  } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan(2^-i) in Q4.20, zero beyond the useful range.
module cordic_atan_rom #(
  parameter int WIDTH = 24,
  parameter int IW    = 5
) (
  input  logic [IW-1:0]           i,
  output logic signed [WIDTH-1:0] atan_o
);

  always_comb begin
    atan_o = '0;
    case (int'(i))
      0:  atan_o = WIDTH'(24'h0C90FE);
      1:  atan_o = WIDTH'(24'h076B1B);
      2:  atan_o = WIDTH'(24'h03EB6F);
      3:  atan_o = WIDTH'(24'h01FD5C);
      4:  atan_o = WIDTH'(24'h00FFAB);
      5:  atan_o = WIDTH'(24'h007FF5);
      6:  atan_o = WIDTH'(24'h003FFF);
      7:  atan_o = WIDTH'(24'h002000);
      8:  atan_o = WIDTH'(24'h001000);
      9:  atan_o = WIDTH'(24'h000800);
      10: atan_o = WIDTH'(24'h000400);
      11: atan_o = WIDTH'(24'h000200);
      12: atan_o = WIDTH'(24'h000100);
      13: atan_o = WIDTH'(24'h000080);
      14: atan_o = WIDTH'(24'h000040);
      15: atan_o = WIDTH'(24'h000020);
      16: atan_o = WIDTH'(24'h000010);
      17: atan_o = WIDTH'(24'h000008);
      18: atan_o = WIDTH'(24'h000004);
      19: atan_o = WIDTH'(24'h000002);
      20: atan_o = WIDTH'(24'h000001);
      21: atan_o = WIDTH'(24'h000001);
      default: atan_o = '0;
    endcase
  end

endmodule

// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring: (x,y) -> atan2 angle and magnitude, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from magnitude.
module cordic_vec_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int ITER  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    data_loaded,
  output logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] magnitude,
  output logic                    data_computed
);

  localparam int DW = WIDTH + 2;
  localparam int CW = $clog2(ITER + 1);
  localparam logic signed [WIDTH-1:0] PI_2_W = WIDTH'(PI_2);

  state_e                  state_q, state_d;
  logic signed [DW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [DW-1:0]    x_sh, y_sh;
  logic signed [WIDTH-1:0] z_q, z_d, angle_q, angle_d, mag_q, mag_d;
  logic signed [WIDTH-1:0] atan_w;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dc_q, dc_d;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH-1:0] K_W = WIDTH'(K);
  logic signed [DW+WIDTH-1:0] prod, prod_rnd;
  assign prod     = x_q * K_W;
  assign prod_rnd = prod + ((DW + WIDTH)'(1) <<< (FRAC - 1));
`endif

  cordic_atan_rom #(.WIDTH(WIDTH), .IW(CW)) u_atan_rom (
    .i      (cnt_q),
    .atan_o (atan_w)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      angle_q <= '0;
      mag_q   <= '0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      dc_q    <= dc_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    dc_d    = 1'b0;
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;

    case (state_q)
      IDLE: begin
        if (data_loaded) begin
          x_d     = {{2{x[WIDTH-1]}}, x};
          y_d     = {{2{y[WIDTH-1]}}, y};
          state_d = PRE;
        end
      end
      PRE: begin
        cnt_d   = '0;
        state_d = ROT;
        z_d     = '0;
        // Fold the left half-plane onto the right; y=0 takes the +pi/2 branch so the result is +pi.
        if (x_q[DW-1]) begin
          if (!y_q[DW-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = PI_2_W;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -PI_2_W;
          end
        end
      end
      ROT: begin
        // A zero vector would otherwise accumulate the whole atan table into z.
        if (|x_q || |y_q) begin
          if (y_q[DW-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_w;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_w;
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = SCALE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE: begin
        x_d     = DW'(prod_rnd >>> FRAC);
        state_d = DONE;
      end
`endif
      DONE: begin
        angle_d = z_q;
        mag_d   = x_q[WIDTH-1:0];
        dc_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign angle         = angle_q;
  assign magnitude     = mag_q;
  assign data_computed = dc_q;

endmodule
